// File: rtl/gray_pkg.sv
// Shared step-class encoding and error-counter sizing for the gray stream decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_stream_decoder_gray2bin.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Gray stream decoder: decodes, classifies each step against the previous word, buffers via output + skid register.
// Optional saturating JUMP counter on err_count is built when GRAY_ERR_CNT_EN is defined.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic [1:0]           out_dir,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: a word moves on any rising edge where valid and ready are both high;
  // the producer holds its word stable until then, and ready never depends on valid.

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] in_bin;
  logic [WIDTH-1:0] diff;
  logic             accept;
  dir_e             in_dir;

  logic             in_ready_q, in_ready_d;
  logic             has_prev_q, has_prev_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  dir_e             out_dir_q, out_dir_d;
  logic             out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_bin_q, skid_bin_d;
  dir_e             skid_dir_q, skid_dir_d;
  logic             skid_err_q, skid_err_d;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (in_gray),
    .bin  (in_bin)
  );

  assign accept = in_valid && in_ready_q;
  assign diff   = in_gray ^ prev_gray_q;

  // A single-bit gray change that is not a +/-1 binary step is still an invalid jump.
  always_comb begin
    in_dir = DIR_HOLD;
    if (has_prev_q && (diff != '0)) begin
      if (($countones(diff) == 1) && (in_bin == prev_bin_q + ONE)) begin
        in_dir = DIR_UP;
      end else if (($countones(diff) == 1) && (in_bin == prev_bin_q - ONE)) begin
        in_dir = DIR_DOWN;
      end else begin
        in_dir = DIR_JUMP;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_bin_d    = out_bin_q;
    out_dir_d    = out_dir_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_bin_d   = skid_bin_q;
    skid_dir_d   = skid_dir_q;
    skid_err_d   = skid_err_q;
    has_prev_d   = has_prev_q;
    prev_gray_d  = prev_gray_q;
    prev_bin_d   = prev_bin_q;

    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_bin_d    = skid_bin_q;
        out_dir_d    = skid_dir_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_bin_d = in_bin;
          out_dir_d = in_dir;
          out_err_d = (in_dir == DIR_JUMP);
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_bin_d   = in_bin;
      skid_dir_d   = in_dir;
      skid_err_d   = (in_dir == DIR_JUMP);
    end

    if (accept) begin
      has_prev_d  = 1'b1;
      prev_gray_d = in_gray;
      prev_bin_d  = in_bin;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      has_prev_q   <= 1'b0;
      prev_gray_q  <= '0;
      prev_bin_q   <= '0;
      out_valid_q  <= 1'b0;
      out_bin_q    <= '0;
      out_dir_q    <= DIR_HOLD;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_bin_q   <= '0;
      skid_dir_q   <= DIR_HOLD;
      skid_err_q   <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      has_prev_q   <= has_prev_d;
      prev_gray_q  <= prev_gray_d;
      prev_bin_q   <= prev_bin_d;
      out_valid_q  <= out_valid_d;
      out_bin_q    <= out_bin_d;
      out_dir_q    <= out_dir_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_bin_q   <= skid_bin_d;
      skid_dir_q   <= skid_dir_d;
      skid_err_q   <= skid_err_d;
    end
  end

`ifdef GRAY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && (in_dir == DIR_JUMP) && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_dir   = out_dir_q;
  assign step_err  = out_err_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: directed streams plus random traffic against a lookup-based reference model.
module tb_gray_stream_decoder;
  import gray_pkg::*;

  localparam int W  = 4;
  localparam int N  = 1 << W;
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_gray = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_bin;
  logic [1:0]   out_dir;
  logic         step_err;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  gray_stream_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_dir   (out_dir),
    .step_err  (step_err),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  bit            m_has_prev = 0;
  int            m_prev_bin = 0;
  int            m_err_cnt  = 0;
  bit            last_acc   = 0;
  bit            hold_pending = 0;
  logic [EW-1:0] held_val;
  int            drv_bin = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int n);
    return (n ^ (n >> 1)) & (N - 1);
  endfunction

  // Decode by searching for the integer whose gray code matches.
  function automatic int decode(input int g);
    for (int n = 0; n < N; n++) begin
      if (to_gray(n) == g) return n;
    end
    return -1;
  endfunction

  function automatic logic [EW-1:0] model_step(input int g);
    int         b;
    logic [1:0] d;
    logic [W-1:0] bv;
    b = decode(g);
    if (!m_has_prev || b == m_prev_bin) d = 2'b00;
    else if (b == (m_prev_bin + 1) % N) d = 2'b01;
    else if (b == (m_prev_bin + N - 1) % N) d = 2'b10;
    else begin
      d = 2'b11;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    m_has_prev = 1;
    m_prev_bin = b;
    bv = b[W-1:0];
    return {bv, d, (d == 2'b11)};
  endfunction

  function automatic int exp_err_count();
`ifdef GRAY_ERR_CNT_EN
    return m_err_cnt;
`else
    return 0;
`endif
  endfunction

  // Input monitor: records accepted words into the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err_count", int'(err_count), exp_err_count());
      last_acc = in_valid && in_ready;
      if (last_acc) exp_q.push_back(model_step(int'(in_gray)));
    end
  end

  // Output monitor: pops and compares each delivered word, checks stability under backpressure.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (hold_pending) check("held_stable", int'({out_bin, out_dir, step_err}), int'(held_val));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_bin", int'(out_bin), int'(e[EW-1:3]));
          check("out_dir", int'(out_dir), int'(e[2:1]));
          check("step_err", int'(step_err), int'(e[0]));
        end
      end
      hold_pending = out_valid && !out_ready;
      held_val = {out_bin, out_dir, step_err};
    end
  end

  task automatic clear_model();
    exp_q.delete();
    m_has_prev   = 0;
    m_prev_bin   = 0;
    m_err_cnt    = 0;
    last_acc     = 0;
    hold_pending = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input int g);
    int t;
    in_valid = 1'b1;
    in_gray  = g[W-1:0];
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int seq_up[5]   = '{0, 1, 3, 2, 6};
    int seq_wrap[3] = '{8, 0, 8};
    int seq_jump[3] = '{0, 3, 2};
    int kind;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_out_dir", int'(out_dir), 0);
    check("rst_step_err", int'(step_err), 0);
    check("rst_err_count", int'(err_count), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", int'(in_ready), 1);

    out_ready = 1'b1;
    foreach (seq_up[i]) send(seq_up[i]);
    drain();

    do_reset();
    foreach (seq_wrap[i]) send(seq_wrap[i]);
    drain();

    do_reset();
    foreach (seq_jump[i]) send(seq_jump[i]);
    drain();

    do_reset();
    out_ready = 1'b0;
    send(1);
    send(3);
    in_valid = 1'b1;
    in_gray  = 4'b0010;
    repeat (2) begin
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2);
    drain();

    do_reset();
    send(3);
    send(3);
    drain();

    do_reset();
    out_ready = 1'b0;
    send(0);
    send(3);
    check("pre_rst_out_valid", int'(out_valid), 1);
    check("pre_rst_skid_full", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_err_count", int'(err_count), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(6);
    drain();

    do_reset();
    for (int i = 0; i < 300; i++) send((i % 2) ? 3 : 0);
    drain();

    do_reset();
    drv_bin = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 3);
        case (kind)
          1: drv_bin = (drv_bin + 1) % N;
          2: drv_bin = (drv_bin + N - 1) % N;
          3: drv_bin = $urandom_range(0, N - 1);
          default: ;
        endcase
        in_gray = to_gray(drv_bin);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
- Streaming consumer placed directly downstream of b2g_converter.
- Accepts a stream of gray-coded words over a valid/ready handshake and decodes each word to binary.
- Classifies each step against the previously accepted word: hold, up, down or invalid jump.
- Presents results through a registered output with a 2-entry skid buffer, giving full throughput and a registered in_ready.

Parameters:
- WIDTH, 4: code width in bits. Must be 2 or greater.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word. Registered.
- in_gray  in  WIDTH  gray-coded input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_bin  out  WIDTH  decoded binary value.
- out_dir  out  2  step class from the package: 00 HOLD, 01 UP, 10 DOWN, 11 JUMP.
- step_err  out  1  asserted with an output word whose out_dir is JUMP.
- err_count  out  8  count of JUMP steps. Always present; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - out_valid=0, out_bin=0, out_dir=HOLD, step_err=0, err_count=0.
  - The skid entry is emptied and has_prev=0.
  - in_ready=1 one cycle after rst_n deasserts. It is held at 0 while rst_n is low.
- Accept rule: a word is accepted when in_valid && in_ready are both high at a clock edge.
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i]. This logic is purely combinational and sits before the storage.
- Step classification, computed at accept time against prev_gray (the last accepted word):
  - has_prev=0: HOLD. This applies to the first word after reset.
  - in_gray==prev_gray: HOLD.
  - popcount(in_gray^prev_gray)==1 and bin==prev_bin+1 mod 2^WIDTH: UP. Wraps from all-ones to 0.
  - popcount==1 and bin==prev_bin-1 mod 2^WIDTH: DOWN.
  - popcount greater than 1: JUMP, with step_err=1.
- On every accept: prev_gray and prev_bin are updated and has_prev is set to 1. A JUMP word also updates them, so the checker resynchronises on the new word.
- Storage is an output register plus one skid register.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 word per cycle while out_ready=1.
- Data movement:
  - When the output register is empty, or out_ready=1, the next word loads into the output register. The skid entry has priority over the incoming word.
  - When the output is held (out_valid=1 and out_ready=0) and a word is accepted, the word goes to the skid register.
  - in_ready is the registered value of !skid_full.
- Order is always preserved. No word is ever dropped or duplicated.
- out_bin, out_dir and step_err are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and output drain with skid full: cannot occur, because in_ready=0 in that state.
- Reset mid-stream: all stored words are discarded. The next accepted word is reported as HOLD.

Optional Feature:
- Macro: GRAY_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each accepted JUMP word.
  - It saturates at 255.
  - It is cleared only by reset.
- Undefined:
  - err_count is tied to 0 and the counter logic is absent.
  - step_err and out_dir behave exactly as when the macro is defined.

Decomposition:
- Package gray_pkg holds:
  - DIR_HOLD, DIR_UP, DIR_DOWN and DIR_JUMP as 2-bit localparams or typedef enum.
  - ERR_CNT_W=8 and ERR_CNT_MAX=255.
- Sub-module gray2bin #(WIDTH) is a combinational decoder, instantiated once.
- The classifier, skid buffer and counter stay in the top module.

Test Plan (WIDTH=4):
- Count up, out_ready=1. Stream 0000, 0001, 0011, 0010, 0110.
  - out_bin: 0, 1, 2, 3, 4, each one cycle after its accept.
  - out_dir: HOLD, UP, UP, UP, UP.
  - step_err stays 0.
- Wrap and down. Stream 1000 (15), 0000 (0), 1000.
  - out_bin: 15, 0, 15.
  - out_dir: HOLD, UP, DOWN.
- Jump. Stream 0000 then 0011.
  - Second word: out_bin=2, out_dir=JUMP, step_err=1.
  - err_count=1 with GRAY_ERR_CNT_EN defined, 0 without.
  - A following 0010 gives UP (resynchronised on 0011).
- Backpressure.
  - Hold out_ready=0 for 4 cycles while in_valid=1 with 0001, 0011, 0010.
  - in_ready falls to 0 after 2 accepts.
  - On releasing out_ready, outputs appear in order 1, 2, then 3 is accepted. No loss.
- Repeat. Stream 0011, 0011.
  - Second word: out_dir=HOLD, step_err=0.
- Reset mid-stream. Assert rst_n low while out_valid=1 and the skid entry is full.
  - out_valid=0 and err_count=0 immediately.
  - After release, the first word 0110 gives out_bin=4, out_dir=HOLD.
